// File: rtl/ahb_slave_sram.sv
// AHB-Lite SRAM slave with configurable wait states and byte-lane writes.
// Define SLAVE_ERR_RESP_EN to answer illegal size/alignment with a two-cycle ERROR response.
module ahb_slave_sram #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HREADY,
  input  logic [31:0]           HWDATA,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int unsigned WORD_AW = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH   = 2 ** WORD_AW;
  localparam int unsigned CNT_W   = 4;

`ifdef SLAVE_ERR_RESP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ERR1 = 2'd2, ERR2 = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1} state_t;
`endif

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               dp_pend;
  logic               wr_q;
  logic               legal_q;
  logic [1:0]         size_q;
  logic [1:0]         lane_q;
  logic [WORD_AW-1:0] widx_q;

  logic [31:0] mem [DEPTH];

  logic        accept_c;
  logic        legal_c;
  logic        wr_commit_c;
  logic [3:0]  be_c;
  logic [31:0] cur_word_c;
  logic [31:0] merged_c;
  logic [31:0] rd_now_c;
  logic        unused_htrans0;

  assign unused_htrans0 = HTRANS[0];

  // Own HREADYOUT gates acceptance so the address bus is ignored while stalling.
  assign accept_c    = HSEL & HREADY & HTRANS[1] & HREADYOUT;
  assign wr_commit_c = dp_pend & (state == IDLE) & wr_q & legal_q;
  assign cur_word_c  = mem[widx_q];

  always_comb begin
    legal_c = 1'b0;
    case (HSIZE)
      3'b000:  legal_c = 1'b1;
      3'b001:  legal_c = ~HADDR[0];
      3'b010:  legal_c = (HADDR[1:0] == 2'b00);
      default: legal_c = 1'b0;
    endcase
  end

  always_comb begin
    be_c = 4'b1111;
    case (size_q)
      2'b00:   be_c = 4'b0001 << lane_q;
      2'b01:   be_c = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be_c = 4'b1111;
    endcase
  end

  always_comb begin
    merged_c = cur_word_c;
    for (int b = 0; b < 4; b++) begin
      if (be_c[b]) merged_c[8*b +: 8] = HWDATA[8*b +: 8];
    end
  end

  // Zero-wait reads launch on the same edge a preceding write commits, so forward it.
  always_comb begin
    rd_now_c = mem[HADDR[ADDR_WIDTH-1:2]];
    if (!legal_c) begin
      rd_now_c = '0;
    end else if (wr_commit_c && (HADDR[ADDR_WIDTH-1:2] == widx_q)) begin
      rd_now_c = merged_c;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET && wr_commit_c) mem[widx_q] <= merged_c;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= IDLE;
      cnt       <= '0;
      dp_pend   <= 1'b0;
      wr_q      <= 1'b0;
      legal_q   <= 1'b0;
      size_q    <= '0;
      lane_q    <= '0;
      widx_q    <= '0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
    end else if (accept_c) begin
      dp_pend <= 1'b1;
      wr_q    <= HWRITE;
      legal_q <= legal_c;
      size_q  <= HSIZE[1:0];
      lane_q  <= HADDR[1:0];
      widx_q  <= HADDR[ADDR_WIDTH-1:2];
`ifdef SLAVE_ERR_RESP_EN
      if (!legal_c) begin
        state     <= ERR1;
        HREADYOUT <= 1'b0;
        HRESP     <= 1'b1;
      end else
`endif
      if (WAIT_STATES != 0) begin
        state     <= WAIT;
        cnt       <= CNT_W'(WAIT_STATES - 1);
        HREADYOUT <= 1'b0;
        HRESP     <= 1'b0;
      end else begin
        state     <= IDLE;
        HREADYOUT <= 1'b1;
        HRESP     <= 1'b0;
        if (!HWRITE) HRDATA <= rd_now_c;
      end
    end else begin
      case (state)
        WAIT: begin
          if (cnt == '0) begin
            state     <= IDLE;
            HREADYOUT <= 1'b1;
            if (!wr_q) HRDATA <= legal_q ? cur_word_c : '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`ifdef SLAVE_ERR_RESP_EN
        ERR1: begin
          state     <= ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        ERR2: begin
          state   <= IDLE;
          HRESP   <= 1'b0;
          dp_pend <= 1'b0;
        end
`endif
        default: begin
          state     <= IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
          dp_pend   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ahb_slave_sram.md
AHB_SLAVE_SRAM -- requirements
Module: ahb_slave_sram

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: local byte-address width; memory depth 2**(ADDR_WIDTH-2) 32-bit words.
REQ-002 Parameter WAIT_STATES, default 1 (legal 0..15): HREADYOUT-low cycles inserted per OKAY data phase.
REQ-003 Port HCLK, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port HRESET, input, 1: reset, synchronous and active-high.
REQ-005 Port HSEL, input, 1: slave select from the address decoder (one HSEL_sN line).
REQ-006 Port HADDR, input, ADDR_WIDTH: local byte address; upper slave-select bits are already stripped.
REQ-007 Ports HWRITE (1), HTRANS (2), HSIZE (3), HREADY (1), inputs: AHB direction, transfer type, size, bus-ready.
REQ-008 Port HWDATA, input, 32: write data, valid in the data phase.
REQ-009 Ports HRDATA (32), HREADYOUT (1), HRESP (1), outputs: read data, slave ready, 1 = ERROR.

Function
REQ-010 A transfer is accepted at edge T only when HSEL=1, HREADY=1 and HTRANS[1]=1 (NONSEQ/SEQ); on acceptance HADDR, HWRITE and HSIZE are latched.
REQ-011 IDLE/BUSY, or HSEL=0 with HREADY=1, produces no data phase activity; HREADYOUT=1, HRESP=0.
REQ-012 FSM states: IDLE, WAIT, ERR1, ERR2.
REQ-013 IDLE->WAIT on a legal acceptance when WAIT_STATES>0; on a legal acceptance with WAIT_STATES=0, the FSM stays in IDLE and the data phase completes in the next cycle.
REQ-014 WAIT: HREADYOUT=0, HRESP=0 for exactly WAIT_STATES cycles; a down-counter reload occurs at acceptance; ->IDLE when the counter reaches 0, giving a completion cycle with HREADYOUT=1.
REQ-015 Legal = HSIZE<=3'b010 and naturally aligned (halfword: HADDR[0]=0; word: HADDR[1:0]=0).
REQ-016 Illegal acceptance (error feature enabled): ->ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then IDLE; no memory write occurs.
REQ-017 Read: HRDATA is registered from the word at latched HADDR[ADDR_WIDTH-1:2], valid in the completion cycle, and is held until the next read completes.
REQ-018 Write: in the completion cycle, HWDATA is sampled and written, updating only the byte lanes selected by HSIZE and the latched HADDR[1:0] (byte lane = HADDR[1:0]; halfword lanes = {HADDR[1],0}+{0,1}).
REQ-019 Pipelining: a new address phase is accepted in the completion cycle of the previous transfer; no idle cycle is required between back-to-back transfers.
REQ-020 Read-after-write to the same word, back-to-back with WAIT_STATES=0, returns the newly written bytes (bypass), merged with the unchanged lanes.
REQ-021 While HREADYOUT=0, HSEL/HADDR/HTRANS are ignored; no acceptance occurs.

Reset
REQ-022 While HRESET=1 at an edge: FSM=IDLE, counter=0, HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-023 Reset during WAIT/ERR1/ERR2 aborts the transfer; a pending write is discarded.
REQ-024 Memory contents are not reset.

Configuration
REQ-025 Macro SLAVE_ERR_RESP_EN defined: illegal transfers take the two-cycle ERROR path of REQ-016.
REQ-026 Macro SLAVE_ERR_RESP_EN undefined: illegal transfers complete as OKAY with normal wait timing; writes are dropped, reads return 32'h0; ERR1/ERR2 are not implemented.

Verification
REQ-027 WAIT_STATES=1; word write 32'hDEADBEEF @0x010, then read @0x010 -> HREADYOUT 0 for 1 cycle in each data phase; read HRDATA=32'hDEADBEEF.
REQ-028 WAIT_STATES=0; word write 32'h11223344 @0x020, then back-to-back byte write 8'hAA (on HWDATA[23:16]) @0x022, then read @0x020 -> HRDATA=32'h11AA3344 with zero wait, bypass exercised.
REQ-029 With SLAVE_ERR_RESP_EN: word write @0x013 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); a subsequent read @0x010 still returns the prior value.
REQ-030 Without SLAVE_ERR_RESP_EN: HSIZE=3'b011 read @0x000 -> OKAY, HRDATA=32'h0, HRESP stays 0.
REQ-031 WAIT_STATES=3; HRESET=1 in the 2nd WAIT cycle of a write 32'hCAFEF00D @0x040 -> next cycle HREADYOUT=1, HRESP=0, HRDATA=0; read @0x040 returns the old value.
REQ-032 HSEL=0 with HTRANS=NONSEQ, or HSEL=1 with HTRANS=IDLE -> no wait, HRESP=0, memory unchanged.
